sdram_burst_sched: RTL and testbench
====================================

// Module: sdram_burst_sched
// PURPOSE
//  Burst scheduler above the SDRAM arbiter for the camera frame buffer. Watches write-FIFO
//  (camera side) and read-FIFO (display side) fill levels, issues wr_req/rd_req with burst
//  addresses, and keeps each request valid until the controller finishes it. Write and read
//  frames are ping-ponged between SDRAM banks 0 and 1, so the display never reads a frame
//  that is still being written.
// PARAMETERS
//  BURST_LEN    10      words per burst; FIFO thresholds and address step
//  FRAME_WORDS  307200  words per frame (640x480); pointer wraps at this value
//  RD_LOW       256     read-FIFO level below which a read burst is wanted
//  CNT_W        11      width of the FIFO level inputs
// PORTS
//  sys_clk         in   1   system clock
//  sys_rst_n       in   1   asynchronous active-low reset
//  init_end        in   1   SDRAM init done (level)
//  wr_fifo_cnt     in   11  words waiting in the write FIFO
//  rd_fifo_cnt     in   11  words held in the read FIFO
//  rd_valid        in   1   display active; reads are permitted only while this is high
//  wr_ack          in   1   arbiter has granted the write (its wr_en)
//  wr_end          in   1   write burst finished, 1-cycle pulse
//  rd_ack          in   1   arbiter has granted the read (its rd_en)
//  rd_end          in   1   read burst finished, 1-cycle pulse
//  wr_req          out  1   write request
//  wr_ba           out  2   write bank {1'b0,wr_pp}
//  wr_addr         out  22  write word address {row[12:0],col[8:0]}
//  rd_req          out  1   read request
//  rd_ba           out  2   read bank {1'b0,rd_pp}
//  rd_addr         out  22  read word address
//  frame_done      out  1   1-cycle pulse when a write frame completes
// BEHAVIOUR
//  Reset values: all outputs 0; wr_ptr=rd_ptr=0; wr_pp=0; rd_pp=1; last_wr=0;
//   frame_ready=0. sys_rst_n has immediate effect, including in the middle of a burst.
//  States: IDLE, CHECK, WR_PEND, WR_RUN, RD_PEND, RD_RUN.
//  IDLE -> CHECK when init_end=1.
//  CHECK evaluates eligibility:
//   we = (wr_fifo_cnt >= BURST_LEN)
//   re = rd_valid & (rd_fifo_cnt < RD_LOW)
//   Only we      -> WR_PEND.
//   Only re      -> RD_PEND.
//   Both         -> RD_PEND if last_wr=1, else WR_PEND (alternation).
//   Neither      -> stay in CHECK.
//  WR_PEND: wr_req=1 (registered, high from the cycle of entry). When wr_ack=1, drop wr_req
//   next cycle -> WR_RUN.
//  WR_RUN: wait for wr_end -> CHECK; set last_wr=1.
//  RD_PEND/RD_RUN: same pattern using rd_req/rd_ack/rd_end; set last_wr=0.
//  wr_end or rd_end arriving while in PEND: treat as ack plus end; go directly to CHECK.
//  Latency: wr_req/rd_req rises 1 clk after CHECK is left. CHECK dwell is at least 1 clk
//   between bursts.
//  Addresses: wr_ba, wr_addr, rd_ba and rd_addr are driven from registers and held stable
//   from request rise through the end pulse.
//  Write pointer at wr_end: if wr_ptr+BURST_LEN >= FRAME_WORDS, then:
//   - wr_ptr <= 0
//   - wr_pp toggles
//   - frame_ready <= 1
//   - frame_done pulses 1 clk
//   Otherwise wr_ptr += BURST_LEN.
//  Read pointer at rd_end: same wrap test. On wrap, rd_ptr <= 0, and if frame_ready=1 then
//   rd_pp <= ~wr_pp (value after any toggle in the same cycle) and frame_ready <= 0.
//   If frame_ready=0, rd_pp is unchanged and the same frame is re-read.
//  Pointer arithmetic uses 22 bits, compared against FRAME_WORDS; a partial last burst is
//   not supported. FRAME_WORDS must be a multiple of BURST_LEN.
//  rd_valid falling in RD_PEND/RD_RUN: the burst completes normally; no new read is issued.
//  init_end falling outside IDLE is ignored.
// TESTING
//  1 Reset, init_end=1, wr_fifo_cnt=10, rd_valid=0 -> wr_req=1 two clks later, wr_ba=0,
//    wr_addr=0; ack then end -> next wr_addr=10.
//  2 Both eligible continuously (wr_fifo_cnt=20, rd_fifo_cnt=0, rd_valid=1) -> grant order
//    W,R,W,R; rd_ba=1 throughout.
//  3 FRAME_WORDS=40: four write bursts -> frame_done pulses on the 4th wr_end, wr_addr=0,
//    wr_ba=1; the next read wrap switches rd_ba to 0.
//  4 Read wrap with frame_ready=0 -> rd_addr returns to 0 and rd_ba is unchanged.
//  5 wr_ack withheld for 50 clks -> wr_req stays high and wr_addr is stable; wr_end with no
//    prior ack -> state returns to CHECK.
//  6 sys_rst_n asserted during WR_RUN -> all outputs 0 immediately; after release,
//    wr_addr restarts at 0.

Source files
------------

// File: rtl/sdram_burst_sched.sv
// Burst scheduler for the camera frame buffer. It issues write and read bursts to the SDRAM
// arbiter and ping-pongs write and read frames between banks 0 and 1.
`timescale 1ns/1ps
module sdram_burst_sched #(
    parameter int BURST_LEN   = 10,
    parameter int FRAME_WORDS = 307200,
    parameter int RD_LOW      = 256,
    parameter int CNT_W       = 11
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             init_end,
    input  logic [CNT_W-1:0] wr_fifo_cnt,
    input  logic [CNT_W-1:0] rd_fifo_cnt,
    input  logic             rd_valid,
    input  logic             wr_ack,
    input  logic             wr_end,
    input  logic             rd_ack,
    input  logic             rd_end,
    output logic             wr_req,
    output logic [1:0]       wr_ba,
    output logic [21:0]      wr_addr,
    output logic             rd_req,
    output logic [1:0]       rd_ba,
    output logic [21:0]      rd_addr,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        IDLE, CHECK, WR_PEND, WR_RUN, RD_PEND, RD_RUN
    } state_t;

    localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] RD_LOW_CNT = CNT_W'(RD_LOW);
    localparam logic [21:0]      STEP       = 22'(BURST_LEN);
    localparam logic [21:0]      FRAME      = 22'(FRAME_WORDS);

    state_t      state, next_state;
    logic [21:0] wr_ptr, rd_ptr;
    logic        wr_pp, rd_pp, last_wr, frame_ready;
    logic        we, re, wr_done, rd_done, wr_wrap, rd_wrap, wr_pp_nxt;

    // An end pulse only counts while its own burst is outstanding.
    always_comb begin
        we        = (wr_fifo_cnt >= BURST_CNT);
        re        = rd_valid && (rd_fifo_cnt < RD_LOW_CNT);
        wr_done   = wr_end && ((state == WR_PEND) || (state == WR_RUN));
        rd_done   = rd_end && ((state == RD_PEND) || (state == RD_RUN));
        wr_wrap   = wr_done && ((wr_ptr + STEP) >= FRAME);
        rd_wrap   = rd_done && ((rd_ptr + STEP) >= FRAME);
        wr_pp_nxt = wr_pp ^ wr_wrap;
    end

    // NOTE: next_state gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (init_end) next_state = CHECK;
            CHECK: begin
                if (we && !(re && last_wr)) next_state = WR_PEND;
                else if (re)                next_state = RD_PEND;
            end
            WR_PEND: begin
                if (wr_end)      next_state = CHECK;
                else if (wr_ack) next_state = WR_RUN;
            end
            WR_RUN:  if (wr_end) next_state = CHECK;
            RD_PEND: begin
                if (rd_end)      next_state = CHECK;
                else if (rd_ack) next_state = RD_RUN;
            end
            RD_RUN:  if (rd_end) next_state = CHECK;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every register here uses non-blocking assignment so all of them update from
    // the same pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= next_state;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_req      <= 1'b0;
            rd_req      <= 1'b0;
            wr_ba       <= '0;
            wr_addr     <= '0;
            rd_ba       <= '0;
            rd_addr     <= '0;
            frame_done  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_pp       <= 1'b0;
            rd_pp       <= 1'b1;
            last_wr     <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            wr_req     <= (next_state == WR_PEND);
            rd_req     <= (next_state == RD_PEND);
            frame_done <= wr_wrap;

            // Addresses are captured as the request rises and held until the next request.
            if ((state == CHECK) && (next_state == WR_PEND)) begin
                wr_addr <= wr_ptr;
                wr_ba   <= {1'b0, wr_pp};
            end
            if ((state == CHECK) && (next_state == RD_PEND)) begin
                rd_addr <= rd_ptr;
                rd_ba   <= {1'b0, rd_pp};
            end

            if (wr_done) begin
                last_wr <= 1'b1;
                wr_ptr  <= wr_wrap ? '0 : wr_ptr + STEP;
            end
            wr_pp <= wr_pp_nxt;

            if (rd_done) begin
                last_wr <= 1'b0;
                rd_ptr  <= rd_wrap ? '0 : rd_ptr + STEP;
            end

            // Display switches to the other bank only once a complete frame exists there.
            if (rd_wrap && frame_ready) rd_pp <= ~wr_pp_nxt;

            if (wr_wrap)                    frame_ready <= 1'b1;
            else if (rd_wrap && frame_ready) frame_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Bench for sdram_burst_sched with a 40-word frame: a small arbiter model answers each
// request, and expected bursts from a vector table are checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_sdram_burst_sched;

    localparam int BURST_LEN   = 10;
    localparam int FRAME_WORDS = 40;
    localparam int RD_LOW      = 256;
    localparam int CNT_W       = 11;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             init_end;
    logic [CNT_W-1:0] wr_fifo_cnt, rd_fifo_cnt;
    logic             rd_valid, wr_ack, wr_end, rd_ack, rd_end;
    logic             wr_req, rd_req, frame_done;
    logic [1:0]       wr_ba, rd_ba;
    logic [21:0]      wr_addr, rd_addr;

    sdram_burst_sched #(
        .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .RD_LOW(RD_LOW), .CNT_W(CNT_W)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
        .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt), .rd_valid(rd_valid),
        .wr_ack(wr_ack), .wr_end(wr_end), .rd_ack(rd_ack), .rd_end(rd_end),
        .wr_req(wr_req), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_ba(rd_ba), .rd_addr(rd_addr), .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        is_wr;
        logic [1:0]  ba;
        logic [21:0] addr;
        logic        fd;
    } exp_t;

    typedef struct packed {
        logic [10:0] wr_cnt;
        logic [10:0] rd_cnt;
        logic        rv;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[14];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cur_req(input logic w);
        return w ? wr_req : rd_req;
    endfunction

    function automatic logic [1:0] cur_ba(input logic w);
        return w ? wr_ba : rd_ba;
    endfunction

    function automatic logic [21:0] cur_addr(input logic w);
        return w ? wr_addr : rd_addr;
    endfunction

    // Wait for the next request, pop its expectation and compare kind and address.
    task automatic wait_req(output exp_t e, output bit ok);
        int waited = 0;
        while (!(wr_req || rd_req) && waited < 100) begin
            @(negedge sys_clk);
            waited++;
        end
        ok = 1'b0;
        e  = '0;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: request seen with no expectation at %0t", $time);
            return;
        end
        e = sb_q.pop_front();
        if (!(wr_req || rd_req)) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: no request within 100 clks, expected is_wr=%0d addr=%0d",
                     e.is_wr, e.addr);
            return;
        end
        ok = 1'b1;
        check("req_kind", wr_req, e.is_wr);
        check("req_exclusive", wr_req & rd_req, 0);
        check("frame_done_clear", frame_done, 0);
        check("req_ba", cur_ba(e.is_wr), e.ba);
        check("req_addr", cur_addr(e.is_wr), e.addr);
    endtask

    // Arbiter model: hold off, optionally ack, then pulse end.
    task automatic service(input int ack_delay, input bit give_ack);
        exp_t e;
        bit   ok;
        bit   held = 1'b1;
        wait_req(e, ok);
        if (!ok) return;
        repeat (ack_delay) begin
            @(negedge sys_clk);
            if (!cur_req(e.is_wr) || cur_ba(e.is_wr) != e.ba || cur_addr(e.is_wr) != e.addr)
                held = 1'b0;
        end
        check("req_held", held, 1);
        if (give_ack) begin
            if (e.is_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
            @(negedge sys_clk);
            wr_ack = 1'b0;
            rd_ack = 1'b0;
            check("req_drop_on_ack", cur_req(e.is_wr), 0);
            repeat (3) @(negedge sys_clk);
            check("addr_stable_run", cur_addr(e.is_wr), e.addr);
        end
        if (e.is_wr) wr_end = 1'b1; else rd_end = 1'b1;
        @(negedge sys_clk);
        wr_end = 1'b0;
        rd_end = 1'b0;
        check("req_low_after_end", wr_req | rd_req, 0);
        check("frame_done", frame_done, e.fd);
    endtask

    task automatic apply(input vec_t v);
        wr_fifo_cnt = v.wr_cnt;
        rd_fifo_cnt = v.rd_cnt;
        rd_valid    = v.rv;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   ok;

        vecs[0]  = '{11'd20, 11'd0,   1'b1, '{1'b0, 2'd1, 22'd0,  1'b0}};
        vecs[1]  = '{11'd20, 11'd0,   1'b1, '{1'b1, 2'd0, 22'd10, 1'b0}};
        vecs[2]  = '{11'd20, 11'd0,   1'b1, '{1'b0, 2'd1, 22'd10, 1'b0}};
        vecs[3]  = '{11'd20, 11'd0,   1'b1, '{1'b1, 2'd0, 22'd20, 1'b0}};
        vecs[4]  = '{11'd20, 11'd0,   1'b0, '{1'b1, 2'd0, 22'd30, 1'b1}};
        vecs[5]  = '{11'd0,  11'd100, 1'b1, '{1'b0, 2'd1, 22'd20, 1'b0}};
        vecs[6]  = '{11'd0,  11'd100, 1'b1, '{1'b0, 2'd1, 22'd30, 1'b0}};
        vecs[7]  = '{11'd10, 11'd0,   1'b0, '{1'b1, 2'd1, 22'd0,  1'b0}};
        vecs[8]  = '{11'd5,  11'd255, 1'b1, '{1'b0, 2'd0, 22'd0,  1'b0}};
        vecs[9]  = '{11'd9,  11'd0,   1'b1, '{1'b0, 2'd0, 22'd10, 1'b0}};
        vecs[10] = '{11'd9,  11'd0,   1'b1, '{1'b0, 2'd0, 22'd20, 1'b0}};
        vecs[11] = '{11'd9,  11'd0,   1'b1, '{1'b0, 2'd0, 22'd30, 1'b0}};
        vecs[12] = '{11'd9,  11'd0,   1'b1, '{1'b0, 2'd0, 22'd0,  1'b0}};
        vecs[13] = '{11'd20, 11'd0,   1'b1, '{1'b1, 2'd1, 22'd10, 1'b0}};

        sys_rst_n   = 1'b0;
        init_end    = 1'b0;
        wr_fifo_cnt = 11'd10;
        rd_fifo_cnt = 11'd0;
        rd_valid    = 1'b0;
        wr_ack      = 1'b0;
        wr_end      = 1'b0;
        rd_ack      = 1'b0;
        rd_end      = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("reset_outputs", {wr_req, wr_ba, wr_addr, rd_req, rd_ba, rd_addr, frame_done}, 0);

        // First write: request rises two clocks after init_end.
        sys_rst_n = 1'b1;
        init_end  = 1'b1;
        @(negedge sys_clk);
        check("t1_no_req_in_check", wr_req, 0);
        @(negedge sys_clk);
        check("t1_req_after_2clk", wr_req, 1);
        sb_q.push_back('{1'b1, 2'd0, 22'd0, 1'b0});
        service(1, 1'b1);

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            sb_q.push_back(vecs[i].exp);
            service(1 + (i % 3), 1'b1);
        end

        // Long ack hold-off, then end with no ack.
        wr_fifo_cnt = 11'd10;
        rd_valid    = 1'b0;
        sb_q.push_back('{1'b1, 2'd1, 22'd20, 1'b0});
        service(50, 1'b0);

        // Neither eligible: wr one short of a burst, rd exactly at the threshold.
        wr_fifo_cnt = 11'd9;
        rd_fifo_cnt = 11'd256;
        rd_valid    = 1'b1;
        begin
            bit quiet = 1'b1;
            repeat (5) begin
                @(negedge sys_clk);
                if (wr_req || rd_req) quiet = 1'b0;
            end
            check("neither_eligible_idle", quiet, 1);
        end

        // Reset in the middle of a write burst.
        wr_fifo_cnt = 11'd10;
        rd_valid    = 1'b0;
        sb_q.push_back('{1'b1, 2'd1, 22'd30, 1'b0});
        wait_req(e, ok);
        wr_ack = 1'b1;
        @(negedge sys_clk);
        wr_ack = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("reset_mid_burst", {wr_req, wr_ba, wr_addr, rd_req, rd_ba, rd_addr, frame_done}, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        sb_q.push_back('{1'b1, 2'd0, 22'd0, 1'b0});
        service(2, 1'b1);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
